// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator keypad sequencer:
//   - default operand / result widths
//   - keypad code points
//   - sequencer state encoding
//   - one-hot ALU opcode constants and key -> opcode mapping
// No ports (package).
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_OPW  = 8;
    localparam int CALC_RESW = 16;

    // Keypad codes; 0..9 are digits, anything above KEY_CLR is ignored.
    localparam logic [4:0] KEY_DIG_MAX = 5'd9;
    localparam logic [4:0] KEY_ADD     = 5'd10;
    localparam logic [4:0] KEY_SUB     = 5'd11;
    localparam logic [4:0] KEY_MUL     = 5'd12;
    localparam logic [4:0] KEY_DIV     = 5'd13;
    localparam logic [4:0] KEY_EXP     = 5'd14;
    localparam logic [4:0] KEY_EQ      = 5'd15;
    localparam logic [4:0] KEY_NEG     = 5'd16;
    localparam logic [4:0] KEY_CLR     = 5'd17;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERR
    } state_e;

    // One-hot opcode, bit order {exp, div, mul, sub, add}
    localparam logic [4:0] OPC_NONE = 5'b00000;
    localparam logic [4:0] OPC_ADD  = 5'b00001;
    localparam logic [4:0] OPC_SUB  = 5'b00010;
    localparam logic [4:0] OPC_MUL  = 5'b00100;
    localparam logic [4:0] OPC_DIV  = 5'b01000;
    localparam logic [4:0] OPC_EXP  = 5'b10000;

    function automatic logic [4:0] key_to_opc(input logic [4:0] code);
        logic [4:0] opc;
        opc = OPC_NONE;
        case (code)
            KEY_ADD: opc = OPC_ADD;
            KEY_SUB: opc = OPC_SUB;
            KEY_MUL: opc = OPC_MUL;
            KEY_DIV: opc = OPC_DIV;
            KEY_EXP: opc = OPC_EXP;
            default: opc = OPC_NONE;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// ----------------------------------------------------------------------------
// calc_digit_acc
// Sign/magnitude decimal accumulator shared by operand A and operand B entry.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr_i             drop current entry (mag=0, sign=+)
//   commit_i          operand taken by the sequencer; restart entry
//   digit_vld_i       append digit_i (mag = mag*10 + digit)
//   digit_i [3:0]     decimal digit
//   neg_i             toggle sign
//   range_err_o       appending digit_i now would push mag above 2^(OPW-1)
//   commit_err_o      positive sign with mag = 2^(OPW-1) (not representable)
//   value_o [OPW-1:0] two's complement value of the current entry
// clr_i/commit_i combined with digit_vld_i/neg_i start a fresh entry that
// already contains that digit / sign.
// ----------------------------------------------------------------------------
module calc_digit_acc #(
    parameter int OPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           commit_i,
    input  logic           digit_vld_i,
    input  logic [3:0]     digit_i,
    input  logic           neg_i,
    output logic           range_err_o,
    output logic           commit_err_o,
    output logic [OPW-1:0] value_o
);

    localparam int MAXMAG = 1 << (OPW - 1);
    localparam int XW     = OPW + 4;   // mag*10+9 with mag <= 2^(OPW-1) fits

    logic [OPW-1:0] mag_q, mag_d;
    logic           sign_q, sign_d;
    logic [XW-1:0]  mag_next;
    logic           restart;

    assign restart  = clr_i || commit_i;
    assign mag_next = ({4'b0000, mag_q} * XW'(10)) + XW'(digit_i);

    // Checked against the held magnitude; a restarted entry only ever
    // receives a single digit, which is always in range.
    assign range_err_o  = (mag_next > XW'(MAXMAG));
    assign commit_err_o = !sign_q && (mag_q == OPW'(MAXMAG));
    assign value_o      = sign_q ? (~mag_q + OPW'(1)) : mag_q;

    always_comb begin
        mag_d  = mag_q;
        sign_d = sign_q;
        if (restart) begin
            mag_d  = digit_vld_i ? OPW'(digit_i) : '0;
            sign_d = neg_i;
        end else begin
            if (digit_vld_i) mag_d = mag_next[OPW-1:0];
            if (neg_i)       sign_d = ~sign_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            sign_q <= sign_d;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// ----------------------------------------------------------------------------
// calc_entry_ctrl
// Keypad-side sequencer for the 8-bit calculator ALU. Builds signed decimal
// operands from keystrokes, presents them with a one-cycle one-hot opcode to
// the combinational ALU, then captures the result or flags an error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   key_valid, key_code[4:0] keypad strobe / code (0-9, ADD..CLR)
//   key_ready                key accepted when key_valid && key_ready
//   k_out, m_out [OPW-1:0]   committed operands A / B to the ALU
//   op_add..op_exp           one-hot opcode, high only during EXEC
//   alu_r [RESW-1:0], alu_ovf ALU result / overflow
//   res [RESW-1:0]           captured result
//   res_valid                res holds the result of the last EQ
//   err                      sticky error, cleared by CLR or rst
// Build option: define CALC_CHAIN_EN to let an op key in SHOW reuse the
// result as operand A; otherwise op keys in SHOW are ignored.
// ----------------------------------------------------------------------------
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int OPW  = CALC_OPW,
    parameter int RESW = CALC_RESW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [4:0]      key_code,
    output logic            key_ready,
    output logic [OPW-1:0]  k_out,
    output logic [OPW-1:0]  m_out,
    output logic            op_add,
    output logic            op_sub,
    output logic            op_mul,
    output logic            op_div,
    output logic            op_exp,
    input  logic [RESW-1:0] alu_r,
    input  logic            alu_ovf,
    output logic [RESW-1:0] res,
    output logic            res_valid,
    output logic            err
);

    state_e          state_q;
    logic [OPW-1:0]  k_q, m_q;
    logic [RESW-1:0] res_q;
    logic            res_valid_q, err_q;
    logic [4:0]      op_q;      // opcode latched at the op key
    logic [4:0]      op_out_q;  // opcode driven to the ALU (EXEC only)
    logic            b_dig_q;   // a B digit has been entered

    logic accept;
    logic k_dig, k_op, k_eq, k_neg, k_clr;
    logic eq_ok, res_fits;

    logic           acc_clr, acc_commit, acc_dig, acc_neg;
    logic           acc_range_err, acc_commit_err;
    logic [OPW-1:0] acc_value;

    assign key_ready = (state_q != ST_EXEC);
    assign accept    = key_valid && key_ready;

    assign k_dig = (key_code <= KEY_DIG_MAX);
    assign k_op  = (key_code >= KEY_ADD) && (key_code <= KEY_EXP);
    assign k_eq  = (key_code == KEY_EQ);
    assign k_neg = (key_code == KEY_NEG);
    assign k_clr = (key_code == KEY_CLR);

    // B=0 for DIV and negative B for EXP are refused before reaching the ALU
    assign eq_ok = !acc_commit_err
                && !((op_q == OPC_DIV) && (acc_value == '0))
                && !((op_q == OPC_EXP) && acc_value[OPW-1]);

    // result is representable as an OPW-bit signed operand
    assign res_fits = (res_q[RESW-1:OPW-1] == '0) || (res_q[RESW-1:OPW-1] == '1);

    calc_digit_acc #(.OPW(OPW)) u_acc (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (acc_clr),
        .commit_i     (acc_commit),
        .digit_vld_i  (acc_dig),
        .digit_i      (key_code[3:0]),
        .neg_i        (acc_neg),
        .range_err_o  (acc_range_err),
        .commit_err_o (acc_commit_err),
        .value_o      (acc_value)
    );

    always_comb begin
        acc_clr    = 1'b0;
        acc_commit = 1'b0;
        acc_dig    = 1'b0;
        acc_neg    = 1'b0;
        if (accept) begin
            if (k_clr) begin
                acc_clr = 1'b1;
            end else begin
                case (state_q)
                    ST_ENTER_A, ST_ENTER_B: begin
                        acc_dig = k_dig && !acc_range_err;
                        acc_neg = k_neg;
                        if (state_q == ST_ENTER_A) acc_commit = k_op && !acc_commit_err;
                        else                       acc_commit = k_eq && eq_ok;
                    end
                    ST_SHOW: begin
                        // a digit or NEG in SHOW starts a brand new operand A
`ifdef CALC_CHAIN_EN
                        acc_clr = k_dig || k_neg || k_op;
`else
                        acc_clr = k_dig || k_neg;
`endif
                        acc_dig = k_dig;
                        acc_neg = k_neg;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTER_A;
            k_q         <= '0;
            m_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= OPC_NONE;
            op_out_q    <= OPC_NONE;
            b_dig_q     <= 1'b0;
        end else begin
            op_out_q <= OPC_NONE;   // one-cycle pulse unless set below
            if (accept && k_clr) begin
                state_q     <= ST_ENTER_A;
                k_q         <= '0;
                m_q         <= '0;
                res_q       <= '0;
                res_valid_q <= 1'b0;
                err_q       <= 1'b0;
                op_q        <= OPC_NONE;
                b_dig_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (accept) begin
                            if (k_dig && acc_range_err) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else if (k_op) begin
                                if (acc_commit_err) begin
                                    state_q <= ST_ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    k_q     <= acc_value;
                                    op_q    <= key_to_opc(key_code);
                                    b_dig_q <= 1'b0;
                                    state_q <= ST_ENTER_B;
                                end
                            end
                        end
                    end
                    ST_ENTER_B: begin
                        if (accept) begin
                            if (k_dig) begin
                                if (acc_range_err) begin
                                    state_q <= ST_ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    b_dig_q <= 1'b1;
                                end
                            end else if (k_op) begin
                                if (!b_dig_q) op_q <= key_to_opc(key_code);
                            end else if (k_eq) begin
                                if (eq_ok) begin
                                    m_q      <= acc_value;
                                    op_out_q <= op_q;
                                    state_q  <= ST_EXEC;
                                end else begin
                                    state_q <= ST_ERR;
                                    err_q   <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (alu_ovf) begin
                            state_q     <= ST_ERR;
                            err_q       <= 1'b1;
                            res_valid_q <= 1'b0;
                        end else begin
                            res_q       <= alu_r;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                        if (accept) begin
                            if (k_dig || k_neg) begin
                                state_q     <= ST_ENTER_A;
                                res_valid_q <= 1'b0;
                            end
`ifdef CALC_CHAIN_EN
                            else if (k_op) begin
                                res_valid_q <= 1'b0;
                                if (res_fits) begin
                                    k_q     <= res_q[OPW-1:0];
                                    op_q    <= key_to_opc(key_code);
                                    b_dig_q <= 1'b0;
                                    state_q <= ST_ENTER_B;
                                end else begin
                                    state_q <= ST_ERR;
                                    err_q   <= 1'b1;
                                end
                            end
`endif
                        end
                    end
                    ST_ERR: ;   // only CLR (handled above) leaves ERR
                    default: state_q <= ST_ENTER_A;
                endcase
            end
        end
    end

`ifndef CALC_CHAIN_EN
    logic unused_fits;
    assign unused_fits = res_fits;
`endif

    assign k_out     = k_q;
    assign m_out     = m_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign op_add    = op_out_q[0];
    assign op_sub    = op_out_q[1];
    assign op_mul    = op_out_q[2];
    assign op_div    = op_out_q[3];
    assign op_exp    = op_out_q[4];

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic [7:0]  k_out, m_out;
    logic        op_add, op_sub, op_mul, op_div, op_exp;
    logic [15:0] alu_r;
    logic        alu_ovf;
    logic [15:0] res;
    logic        res_valid;
    logic        err;

    logic        force_ovf;
    logic [4:0]  ops;
    logic signed [15:0] sa, sb, pw;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .k_out     (k_out),
        .m_out     (m_out),
        .op_add    (op_add),
        .op_sub    (op_sub),
        .op_mul    (op_mul),
        .op_div    (op_div),
        .op_exp    (op_exp),
        .alu_r     (alu_r),
        .alu_ovf   (alu_ovf),
        .res       (res),
        .res_valid (res_valid),
        .err       (err)
    );

    assign ops     = {op_exp, op_div, op_mul, op_sub, op_add};
    assign alu_ovf = force_ovf;

    // Simple behavioural ALU so captured results are meaningful
    always_comb begin
        sa = {{8{k_out[7]}}, k_out};
        sb = {{8{m_out[7]}}, m_out};
        pw = 16'sd1;
        for (int i = 0; i < 16; i++) if (16'(i) < sb) pw = pw * sa;
        case (ops)
            5'b00001: alu_r = sa + sb;
            5'b00010: alu_r = sa - sb;
            5'b00100: alu_r = sa * sb;
            5'b01000: alu_r = (sb != 0) ? sa / sb : 16'h0000;
            5'b10000: alu_r = pw;
            default:  alu_r = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 5'd31;
    endtask

    localparam logic [4:0] ADD = 5'd10, SUB = 5'd11, MUL = 5'd12, DIV = 5'd13,
                           EXP = 5'd14, EQ = 5'd15, NEG = 5'd16, CLR = 5'd17;

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'd31;
        force_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_ready", key_ready, 1);
        chk("rst_k", k_out, 0);
        chk("rst_m", m_out, 0);
        chk("rst_res", res, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ops", ops, 0);

        // 12 + 30
        press(5'd1); press(5'd2); press(ADD); press(5'd3); press(5'd0); press(EQ);
        chk("add_ops", ops, 5'b00001);
        chk("add_ready", key_ready, 0);
        chk("add_k", k_out, 8'h0C);
        chk("add_m", m_out, 8'h1E);
        chk("add_rv_t1", res_valid, 0);
        @(posedge clk); #1;
        chk("add_res", res, 16'h002A);
        chk("add_rv_t2", res_valid, 1);
        chk("add_ops_off", ops, 0);
        chk("add_ready2", key_ready, 1);

        // -5 * 7, new A started from SHOW by a digit
        press(5'd5);
        chk("show_dig_rv", res_valid, 0);
        press(NEG); press(MUL); press(5'd7); press(EQ);
        chk("mul_ops", ops, 5'b00100);
        chk("mul_k", k_out, 8'hFB);
        chk("mul_m", m_out, 8'h07);
        @(posedge clk); #1;
        chk("mul_res", res, 16'hFFDD);
        chk("mul_err", err, 0);

        // 100 / 0 -> error, no pulse
        press(5'd1); press(5'd0); press(5'd0); press(DIV); press(5'd0); press(EQ);
        chk("div0_err", err, 1);
        chk("div0_ops", ops, 0);
        @(posedge clk); #1;
        chk("div0_ops2", ops, 0);
        chk("div0_rv", res_valid, 0);
        press(5'd4);   // discarded in ERR
        chk("err_sticky", err, 1);
        press(CLR);
        chk("clr_err", err, 0);
        chk("clr_k", k_out, 0);
        chk("clr_res", res, 0);

        // magnitude range
        press(5'd1); press(5'd3);
        chk("r130_pre", err, 0);
        press(5'd0);
        chk("r130_err", err, 1);
        press(CLR);
        press(5'd1); press(5'd2); press(5'd8); press(ADD);
        chk("p128_err", err, 1);
        press(CLR);
        press(5'd1); press(5'd2); press(5'd8); press(NEG); press(ADD);
        chk("n128_k", k_out, 8'h80);
        chk("n128_err", err, 0);
        // SUB replaces ADD (no B digit yet), MUL after a digit is ignored
        press(SUB); press(5'd2); press(MUL); press(EQ);
        chk("repl_ops", ops, 5'b00010);
        @(posedge clk); #1;
        chk("repl_res", res, 16'hFF7E);

        // overflow in EXEC: no capture, error
        press(CLR);
        press(5'd2); press(EXP); press(5'd9);
        force_ovf = 1'b1;
        press(EQ);
        chk("ovf_ops", ops, 5'b10000);
        @(posedge clk); #1;
        force_ovf = 1'b0;
        chk("ovf_err", err, 1);
        chk("ovf_rv", res_valid, 0);
        chk("ovf_res", res, 0);

        // reset during EXEC
        press(CLR);
        press(5'd3); press(ADD); press(5'd4); press(EQ);
        chk("rx_ops", ops, 5'b00001);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rx_k", k_out, 0);
        chk("rx_m", m_out, 0);
        chk("rx_res", res, 0);
        chk("rx_rv", res_valid, 0);
        chk("rx_ops0", ops, 0);
        chk("rx_ready", key_ready, 1);

        // chaining from SHOW
        press(5'd4); press(5'd2); press(ADD); press(5'd0); press(EQ);
        @(posedge clk); #1;
        chk("ch_res0", res, 16'h002A);
        press(ADD);
`ifdef CALC_CHAIN_EN
        chk("ch_k", k_out, 8'h2A);
        press(5'd8); press(EQ);
        chk("ch_ops", ops, 5'b00001);
        @(posedge clk); #1;
        chk("ch_res", res, 16'h0032);
`else
        chk("noch_rv", res_valid, 1);
        press(5'd8); press(EQ);
        chk("noch_ops", ops, 0);
        chk("noch_rv2", res_valid, 0);
        chk("noch_res", res, 16'h002A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
